// File: rtl/bl_wl_cfg_pkg.sv
// Shared types and defaults for the bit-line / word-line configuration driver.
package bl_wl_cfg_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_SETUP = 3'd1,
      ST_PULSE = 3'd2,
      ST_HOLD  = 3'd3,
      ST_DONE  = 3'd4
   } state_t;

   localparam int WL_PULSE_CYCLES_DEF = 2;

   // Address width for n word lines, never narrower than one bit.
   function automatic int addr_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/wl_onehot_decoder.sv
// Word-line index to one-hot decode with an out-of-range flag.
module wl_onehot_decoder #(
   parameter int WL_WIDTH = 8,
   parameter int AW       = 3
) (
   input  logic [AW-1:0]       addr,
   input  logic                enable,
   output logic [WL_WIDTH-1:0] wl,
   output logic                out_of_range
);

   always_comb begin
      out_of_range = (int'(addr) >= WL_WIDTH);
      wl           = '0;
      for (int i = 0; i < WL_WIDTH; i++) begin
         wl[i] = enable && (addr == AW'(i));
      end
   end

endmodule

// File: rtl/bl_wl_config_driver.sv
// Row-at-a-time bit-line/word-line programming sequencer.
// Optional even-parity check on cfg_data with BL_WL_CFG_PARITY_EN.
//
// state | meaning
// IDLE  | cfg_ready high, waiting for a row; bl and wl low
// SETUP | bl driven with row data, wl low
// PULSE | one word line high for WL_PULSE_CYCLES clocks
// HOLD  | wl low, bl still driven
// DONE  | one-cycle done pulse after the last row
module bl_wl_config_driver
   import bl_wl_cfg_pkg::*;
#(
   parameter int BL_WIDTH        = 8,
   parameter int WL_WIDTH        = 8,
   parameter int WL_PULSE_CYCLES = WL_PULSE_CYCLES_DEF
) (
   input  logic                                 prog_clk,
   input  logic                                 prog_rst_n,
   input  logic                                 cfg_valid,
   output logic                                 cfg_ready,
   input  logic [BL_WIDTH-1:0]                  cfg_data,
   input  logic [addr_width(WL_WIDTH)-1:0]      cfg_wl_addr,
   input  logic                                 cfg_last,
`ifdef BL_WL_CFG_PARITY_EN
   input  logic                                 cfg_parity,
`endif
   output logic [BL_WIDTH-1:0]                  bl,
   output logic [WL_WIDTH-1:0]                  wl,
   output logic                                 busy,
   output logic                                 done,
   output logic                                 err
);

   localparam int AW = addr_width(WL_WIDTH);
   localparam int CW = $clog2(WL_PULSE_CYCLES + 1);
   localparam logic [CW-1:0] CNT_LOAD = CW'(WL_PULSE_CYCLES - 1);

   state_t                state;
   logic [WL_WIDTH-1:0]   wl_row_q;
   logic                  last_q;
   logic                  done_seen;
   logic [CW-1:0]         cnt;
   logic                  par_bad;
   logic [WL_WIDTH-1:0]   dec_wl;
   logic                  dec_oor;

`ifdef BL_WL_CFG_PARITY_EN
   assign par_bad = (^cfg_data) != cfg_parity;
`else
   assign par_bad = 1'b0;
`endif

   // A bad row decodes to all zeros so its pulse window drives no word line.
   wl_onehot_decoder #(
      .WL_WIDTH (WL_WIDTH),
      .AW       (AW)
   ) u_dec (
      .addr         (cfg_wl_addr),
      .enable       (!par_bad),
      .wl           (dec_wl),
      .out_of_range (dec_oor)
   );

   always_ff @(posedge prog_clk or negedge prog_rst_n) begin
      if (!prog_rst_n) begin
         state     <= ST_IDLE;
         cfg_ready <= 1'b0;
         bl        <= '0;
         wl        <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
         err       <= 1'b0;
         wl_row_q  <= '0;
         last_q    <= 1'b0;
         done_seen <= 1'b0;
         cnt       <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (cfg_valid && cfg_ready) begin
                  bl        <= cfg_data;
                  wl_row_q  <= dec_wl;
                  last_q    <= cfg_last;
                  err       <= (err & ~done_seen) | dec_oor | par_bad;
                  done_seen <= 1'b0;
                  cfg_ready <= 1'b0;
                  busy      <= 1'b1;
                  state     <= ST_SETUP;
               end else begin
                  cfg_ready <= 1'b1;
               end
            end
            ST_SETUP: begin
               wl    <= wl_row_q;
               cnt   <= CNT_LOAD;
               state <= ST_PULSE;
            end
            ST_PULSE: begin
               if (cnt == '0) begin
                  wl    <= '0;
                  state <= ST_HOLD;
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            ST_HOLD: begin
               bl <= '0;
               if (last_q) begin
                  done  <= 1'b1;
                  state <= ST_DONE;
               end else begin
                  cfg_ready <= 1'b1;
                  busy      <= 1'b0;
                  state     <= ST_IDLE;
               end
            end
            ST_DONE: begin
               done_seen <= 1'b1;
               cfg_ready <= 1'b1;
               busy      <= 1'b0;
               state     <= ST_IDLE;
            end
            default: begin
               bl        <= '0;
               wl        <= '0;
               cfg_ready <= 1'b0;
               busy      <= 1'b0;
               state     <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_bl_wl_config_driver.sv
// Directed bench for bl_wl_config_driver: an 8-line and a 10-line instance.
module tb_bl_wl_config_driver;

   logic       prog_clk = 1'b0;
   logic       prog_rst_n = 1'b0;

   logic       valid_a = 1'b0, ready_a, last_a = 1'b0, par_a = 1'b0;
   logic [7:0] data_a = '0, bl_a, wl_a;
   logic [2:0] addr_a = '0;
   logic       busy_a, done_a, err_a;

   logic       valid_b = 1'b0, ready_b, last_b = 1'b0, par_b = 1'b0;
   logic [7:0] data_b = '0, bl_b;
   logic [3:0] addr_b = '0;
   logic [9:0] wl_b;
   logic       busy_b, done_b, err_b;

   int n_cmp = 0;
   int n_err = 0;

   always #5 prog_clk = ~prog_clk;

   bl_wl_config_driver dut_a (
      .prog_clk    (prog_clk),
      .prog_rst_n  (prog_rst_n),
      .cfg_valid   (valid_a),
      .cfg_ready   (ready_a),
      .cfg_data    (data_a),
      .cfg_wl_addr (addr_a),
      .cfg_last    (last_a),
`ifdef BL_WL_CFG_PARITY_EN
      .cfg_parity  (par_a),
`endif
      .bl          (bl_a),
      .wl          (wl_a),
      .busy        (busy_a),
      .done        (done_a),
      .err         (err_a)
   );

   bl_wl_config_driver #(.WL_WIDTH(10)) dut_b (
      .prog_clk    (prog_clk),
      .prog_rst_n  (prog_rst_n),
      .cfg_valid   (valid_b),
      .cfg_ready   (ready_b),
      .cfg_data    (data_b),
      .cfg_wl_addr (addr_b),
      .cfg_last    (last_b),
`ifdef BL_WL_CFG_PARITY_EN
      .cfg_parity  (par_b),
`endif
      .bl          (bl_b),
      .wl          (wl_b),
      .busy        (busy_b),
      .done        (done_b),
      .err         (err_b)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(negedge prog_clk);
   endtask

   // One complete row on the 8-line instance; starts and ends idle at a falling edge.
   task automatic row_a(input logic [7:0] d, input logic [2:0] a, input logic l,
                        input logic p, input logic [7:0] ew, input logic ee);
      chk("a_ready_idle", 32'(ready_a), 1);
      valid_a = 1'b1; data_a = d; addr_a = a; last_a = l; par_a = p;
      tick();
      valid_a = 1'b0;
      chk("a_setup_bl", 32'(bl_a), 32'(d));
      chk("a_setup_wl", 32'(wl_a), 0);
      chk("a_setup_busy", 32'(busy_a), 1);
      chk("a_setup_ready", 32'(ready_a), 0);
      chk("a_setup_err", 32'(err_a), 32'(ee));
      for (int i = 0; i < 2; i++) begin
         tick();
         chk("a_pulse_wl", 32'(wl_a), 32'(ew));
         chk("a_pulse_bl", 32'(bl_a), 32'(d));
      end
      tick();
      chk("a_hold_wl", 32'(wl_a), 0);
      chk("a_hold_bl", 32'(bl_a), 32'(d));
      chk("a_hold_done", 32'(done_a), 0);
      tick();
      if (l) begin
         chk("a_done", 32'(done_a), 1);
         chk("a_done_bl", 32'(bl_a), 0);
         chk("a_done_busy", 32'(busy_a), 1);
         tick();
      end
      chk("a_idle_done", 32'(done_a), 0);
      chk("a_idle_ready", 32'(ready_a), 1);
      chk("a_idle_busy", 32'(busy_a), 0);
      chk("a_idle_bl", 32'(bl_a), 0);
   endtask

   task automatic row_b(input logic [7:0] d, input logic [3:0] a, input logic l,
                        input logic [9:0] ew, input logic ee);
      chk("b_ready_idle", 32'(ready_b), 1);
      valid_b = 1'b1; data_b = d; addr_b = a; last_b = l; par_b = ^d;
      tick();
      valid_b = 1'b0;
      chk("b_setup_bl", 32'(bl_b), 32'(d));
      chk("b_setup_wl", 32'(wl_b), 0);
      chk("b_setup_err", 32'(err_b), 32'(ee));
      for (int i = 0; i < 2; i++) begin
         tick();
         chk("b_pulse_wl", 32'(wl_b), 32'(ew));
         chk("b_pulse_bl", 32'(bl_b), 32'(d));
      end
      tick();
      chk("b_hold_wl", 32'(wl_b), 0);
      tick();
      if (l) begin
         chk("b_done", 32'(done_b), 1);
         chk("b_done_wl", 32'(wl_b), 0);
         tick();
      end
      chk("b_idle_ready", 32'(ready_b), 1);
      chk("b_idle_err", 32'(err_b), 32'(ee));
   endtask

   initial begin
      int         hs_cyc[8];
      int         row;
      int         cur;
      int         done_cnt;
      int         max_ones;
      logic [7:0] row_data;

      // Reset values
      tick();
      tick();
      chk("rst_bl", 32'(bl_a), 0);
      chk("rst_wl", 32'(wl_a), 0);
      chk("rst_busy", 32'(busy_a), 0);
      chk("rst_done", 32'(done_a), 0);
      chk("rst_err", 32'(err_a), 0);
      chk("rst_ready", 32'(ready_a), 0);
      chk("rst_ready_b", 32'(ready_b), 0);
      prog_rst_n = 1'b1;
      tick();
      chk("rel_ready", 32'(ready_a), 1);

      // Single last row, A5 on word line 3
      row_a(8'hA5, 3'd3, 1'b1, 1'b0, 8'b0000_1000, 1'b0);

      // Eight back-to-back rows with cfg_valid held high
      row = 0; cur = 0; done_cnt = 0; max_ones = 0;
      for (int c = 0; c < 60; c++) begin
         if ($countones(wl_a) > max_ones) max_ones = $countones(wl_a);
         if (wl_a != '0) begin
            chk("bb_wl", 32'(wl_a), 32'(1) << cur);
            chk("bb_bl", 32'(bl_a), 32'(8'h11 * (cur + 1)));
         end
         if (done_a) done_cnt++;
         if (row < 8) begin
            row_data = 8'(8'h11 * (row + 1));
            valid_a  = 1'b1;
            data_a   = row_data;
            addr_a   = 3'(row);
            last_a   = (row == 7);
            if (ready_a) begin
               hs_cyc[row] = c;
               cur = row;
               row++;
            end
         end else begin
            valid_a = 1'b0;
         end
         tick();
      end
      valid_a = 1'b0;
      chk("bb_rows", 32'(row), 8);
      for (int r = 1; r < 8; r++) chk("bb_spacing", 32'(hs_cyc[r] - hs_cyc[r-1]), 5);
      chk("bb_max_onehot", 32'(max_ones), 1);
      chk("bb_done_count", 32'(done_cnt), 1);
      chk("bb_ready_end", 32'(ready_a), 1);

      // Ten word lines: top index, out of range, then err clears after done
      row_b(8'h5A, 4'd9,  1'b1, 10'h200, 1'b0);
      row_b(8'hC3, 4'd10, 1'b1, 10'h000, 1'b1);
      row_b(8'h0F, 4'd2,  1'b0, 10'h004, 1'b0);

      // Reset asserted in the middle of a pulse
      chk("mid_ready", 32'(ready_a), 1);
      valid_a = 1'b1; data_a = 8'h3C; addr_a = 3'd5; last_a = 1'b0;
      tick();
      valid_a = 1'b0;
      tick();
      chk("mid_pulse_wl", 32'(wl_a), 32'h20);
      #2 prog_rst_n = 1'b0;
      #1;
      chk("mid_rst_wl", 32'(wl_a), 0);
      chk("mid_rst_bl", 32'(bl_a), 0);
      chk("mid_rst_busy", 32'(busy_a), 0);
      chk("mid_rst_ready", 32'(ready_a), 0);
      tick();
      prog_rst_n = 1'b1;
      tick();
      chk("mid_rel_ready", 32'(ready_a), 1);
      chk("mid_rel_wl", 32'(wl_a), 0);
      chk("mid_rel_busy", 32'(busy_a), 0);
      tick();
      chk("mid_no_resume", 32'(wl_a), 0);

`ifdef BL_WL_CFG_PARITY_EN
      // Parity error suppresses the pulse; a clean row after done clears err
      row_a(8'h01, 3'd1, 1'b1, 1'b0, 8'h00, 1'b1);
      row_a(8'h01, 3'd2, 1'b1, 1'b1, 8'h04, 1'b0);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/bl_wl_config_driver.md
BL_WL_CONFIG_DRIVER -- requirements
Module: bl_wl_config_driver

Interface
REQ-001 SHALL have parameter BL_WIDTH, default 8: number of bit lines driven.
REQ-002 SHALL have parameter WL_WIDTH, default 8: number of word lines driven.
REQ-003 SHALL have parameter WL_PULSE_CYCLES, default 2, legal range 1..15: word-line high time in clocks.
REQ-004 SHALL have port prog_clk  input  1  programming clock; all logic on its rising edge.
REQ-005 SHALL have port prog_rst_n  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port cfg_valid  input  1  row word offered.
REQ-007 SHALL have port cfg_ready  output  1  row word accepted when cfg_valid and cfg_ready are both high.
REQ-008 SHALL have port cfg_data  input  BL_WIDTH  bit-line pattern for one row.
REQ-009 SHALL have port cfg_wl_addr  input  clog2(WL_WIDTH)  target word-line index.
REQ-010 SHALL have port cfg_last  input  1  final row of the bitstream.
REQ-011 SHALL have port bl  output  BL_WIDTH  bit lines; index 0 is the first tile bit.
REQ-012 SHALL have port wl  output  WL_WIDTH  word lines; at most one bit is high at any time.
REQ-013 SHALL have port busy  output  1  high in every state except IDLE.
REQ-014 SHALL have port done  output  1  one-cycle pulse after the last row completes.
REQ-015 SHALL have port err  output  1  sticky error flag.

Function
REQ-016 SHALL implement the FSM states IDLE, SETUP, PULSE, HOLD and DONE.
REQ-017 SHALL drive cfg_ready high only in IDLE.
REQ-018 SHALL, on a handshake at edge k, register cfg_data, cfg_wl_addr and cfg_last, and enter SETUP.
REQ-019 SHALL, in SETUP (one cycle), drive bl with the registered data and hold wl at all zeros.
REQ-020 SHALL, in PULSE, drive wl one-hot at the registered address for exactly WL_PULSE_CYCLES cycles, with bl held stable.
REQ-021 SHALL, in HOLD (one cycle), hold wl at zero and keep bl stable, then go to DONE if the registered cfg_last is set, else to IDLE.
REQ-022 SHALL stay in DONE for one cycle with done=1, then go to IDLE.
REQ-023 SHALL therefore accept rows at most once per WL_PULSE_CYCLES+3 cycles, plus 1 cycle after a last row.
REQ-024 SHALL drive bl to zero in IDLE and DONE.
REQ-025 SHALL, when cfg_wl_addr >= WL_WIDTH, accept the row, set err, and keep wl at zero through the full sequence (timing unchanged).
REQ-026 SHALL clear err on the first handshake that follows a done pulse; an error on that same row sets err again.
REQ-027 SHALL use a PULSE counter of width clog2(WL_PULSE_CYCLES+1) that never wraps.
REQ-028 SHALL ignore the cfg_* inputs outside IDLE; holding cfg_valid high produces back-to-back rows at the REQ-023 rate.

Reset
REQ-029 SHALL, while prog_rst_n is low, force the state to IDLE and all outputs to: bl=0, wl=0, busy=0, done=0, err=0, cfg_ready=0.
REQ-030 SHALL, on reset assertion mid-PULSE, drop wl immediately (asynchronously) and discard the row in progress.
REQ-031 SHALL raise cfg_ready on the first prog_clk edge after reset is deasserted.

Configuration
REQ-032 SHALL, with macro BL_WL_CFG_PARITY_EN defined, add input cfg_parity (1 bit, even parity over cfg_data).
REQ-033 SHALL, under BL_WL_CFG_PARITY_EN, treat a parity mismatch as in REQ-025: set err, keep wl at zero, timing unchanged.
REQ-034 SHALL, without BL_WL_CFG_PARITY_EN, have no cfg_parity port and no parity logic.

Structure
REQ-035 SHALL place the FSM state enum and the default WL_PULSE_CYCLES constant in the shared package bl_wl_cfg_pkg.
REQ-036 SHALL implement the one-hot decode as sub-module wl_onehot_decoder (inputs: address, enable; outputs: WL_WIDTH bits and an out-of-range flag).

Verification
REQ-037 Bench SHALL cover: one row, data=8'hA5, addr=3, last=1 -> bl=A5 from cycle k+1; wl=8'b00001000 in cycles k+2..k+3; done=1 at k+5; cfg_ready high at k+6.
REQ-038 Bench SHALL cover: 8 rows addr 0..7 with cfg_valid held high -> handshakes exactly 5 cycles apart; wl one-hot each time, never two bits high; a single done pulse.
REQ-039 Bench SHALL cover: addr=9 with WL_WIDTH=10 -> accepted; addr=10 -> err=1 and wl stays 0 for the full sequence.
REQ-040 Bench SHALL cover: prog_rst_n pulsed low mid-PULSE -> wl=0 and bl=0 in the same cycle; cfg_ready=1 on the first edge after release.
REQ-041 Bench SHALL cover: with BL_WL_CFG_PARITY_EN, data=8'h01 and cfg_parity=0 -> err=1 and no wl pulse; next row after done with correct parity -> err clears.
